// File: rtl/div_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller states and the fixed restoring-division constants.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV1 = 2'd1,
        DIV2 = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] DIV_CONST     = 4'd10;
    localparam int         STEPS_PER_DIV = 8;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the partial remainder left, bring in
// the next numerator bit, subtract the divisor when it fits.
module div_step
    import div_pkg::*;
(
    input  logic [4:0] rem_in,
    input  logic       bit_in,
    input  logic [3:0] divisor,
    output logic [4:0] rem_out,
    output logic       q_bit
);

    logic [4:0] shifted;
    logic       fits;

    // Trial subtraction; rem_in[4] would mean the shifted value is already
    // past 31, which can only be >= divisor, so it forces a subtract.
    always_comb begin
        shifted = {rem_in[3:0], bit_in};
        fits    = rem_in[4] | (shifted >= {1'b0, divisor});
        q_bit   = fits;
        rem_out = fits ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter. Two back-to-back
// 8-step restoring divisions by 10: the first yields ones and a quotient
// (0..25), the second splits that quotient into tens and hundreds.
// Latency is fixed at 16 edges from accept to out_valid.
module bin2bcd_seq
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS_PER_DIV - 1);

    state_t     state;
    logic [7:0] num;
    logic [4:0] rem;
    logic [2:0] cnt;
    logic [3:0] ones;

    logic [4:0] step_rem;
    logic       step_q;
    logic [7:0] next_num;

    // Single shared step unit; the numerator MSB feeds it in both phases.
    div_step u_step (
        .rem_in  (rem),
        .bit_in  (num[7]),
        .divisor (DIV_CONST),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Numerator register shifts out its MSB and collects quotient bits at
    // the LSB, so after 8 steps it holds the quotient.
    always_comb begin
        next_num = {num[6:0], step_q};
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Controller and datapath: accept, two division phases, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num       <= 8'd0;
            rem       <= 5'd0;
            cnt       <= 3'd0;
            ones      <= 4'd0;
            bcd       <= 12'h000;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        num   <= in_data;
                        rem   <= 5'd0;
                        cnt   <= 3'd0;
                        state <= DIV1;
                    end
                end
                DIV1: begin
                    num <= next_num;
                    if (cnt == LAST_STEP) begin
                        ones  <= step_rem[3:0];
                        rem   <= 5'd0;
                        cnt   <= 3'd0;
                        state <= DIV2;
                    end else begin
                        rem <= step_rem;
                        cnt <= cnt + 3'd1;
                    end
                end
                DIV2: begin
                    num <= next_num;
                    if (cnt == LAST_STEP) begin
                        bcd       <= {next_num[3:0], step_rem[3:0], ones};
                        rem       <= 5'd0;
                        cnt       <= 3'd0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem <= step_rem;
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, hand-written
// handshake/reset sequences, and a full operand sweep with random stalls.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        busy;

    int tests = 0;
    int fails = 0;

    bin2bcd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  value;
        int          stall;
        logic [11:0] exp_bcd;
    } vec_t;

    // Reference: decimal digits by plain arithmetic.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction; called just after a falling edge.
    task automatic run_op(input logic [7:0] v, input int stall, input logic [11:0] exp, input string tag);
        int  lat;
        int  waitc;
        bit  bad_busy;
        bit  bad_hold;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        bad_busy = 1'b0;
        if (!busy || in_ready || out_valid) bad_busy = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (!busy || in_ready) bad_busy = 1'b1;
            // garbage on the inputs while busy must be ignored
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, " busy/in_ready during op"}, 32'(bad_busy), 32'd0);
        check({tag, " latency"}, 32'(lat), 32'd16);
        check({tag, " bcd"}, 32'(bcd), 32'(exp));
        check({tag, " in_ready with out_valid"}, 32'(in_ready), 32'd0);
        bad_hold = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || bcd !== exp || in_ready || !busy) bad_hold = 1'b1;
        end
        if (stall > 0) check({tag, " hold during stall"}, 32'(bad_hold), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " idle after ack"}, 32'({in_ready, busy}), 32'b10);
    endtask

    vec_t vecs[6];

    initial begin
        int   idx;
        int   nres;
        int   ir_run;
        bit   bad_seq;
        bit   prev_ov;
        bit   bad_ov;
        logic [7:0]  seq_in[3];
        logic [11:0] seq_exp[3];

        vecs[0] = '{8'd255, 0, 12'h255};
        vecs[1] = '{8'd199, 5, 12'h199};
        vecs[2] = '{8'd10,  1, 12'h010};
        vecs[3] = '{8'd1,   0, 12'h001};
        vecs[4] = '{8'd128, 2, 12'h128};
        vecs[5] = '{8'd99,  0, 12'h099};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset bcd", 32'(bcd), 32'h000);
        check("reset busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 6; i++)
            run_op(vecs[i].value, vecs[i].stall, vecs[i].exp_bcd, $sformatf("vec%0d", i));

        // Back-to-back with in_valid and out_ready held high
        seq_in[0] = 8'd0;   seq_exp[0] = 12'h000;
        seq_in[1] = 8'd100; seq_exp[1] = 12'h100;
        seq_in[2] = 8'd9;   seq_exp[2] = 12'h009;
        idx = 0; nres = 0; ir_run = 0; bad_seq = 1'b0; prev_ov = 1'b0; bad_ov = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 120 && nres < 3; c++) begin
            if (in_ready) begin
                ir_run++;
                if (ir_run > 1 && idx < 3) bad_seq = 1'b1;
                if (idx < 3) begin
                    in_data = seq_in[idx];
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                ir_run = 0;
            end
            if (out_valid) begin
                if (in_ready || prev_ov) bad_ov = 1'b1;
                check($sformatf("b2b result%0d", nres), 32'(bcd), 32'(seq_exp[nres]));
                nres++;
            end
            prev_ov = out_valid;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b result count", 32'(nres), 32'd3);
        check("b2b in_ready low between accepts", 32'(bad_seq), 32'd0);
        check("b2b out_valid single cycle", 32'(bad_ov), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in the middle of an operation
        in_valid = 1'b1;
        in_data  = 8'd87;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst bcd", 32'(bcd), 32'h000);
        check("midrst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad_ov = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid || !in_ready) bad_ov = 1'b1;
        end
        check("midrst no out_valid, idle", 32'(bad_ov), 32'd0);
        run_op(8'd42, 0, 12'h042, "after_rst");

        // Exhaustive sweep with random stalls against the arithmetic model
        for (int v = 0; v < 256; v++)
            run_op(8'(v), int'($urandom_range(0, 3)), to_bcd(v), $sformatf("sweep%0d", v));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
